// File: rtl/sort_pkg.sv
// Shared types and default sizes for the in-place bubble-sort sequencer.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        OUT
    } state_t;

    localparam int SORT_WIDTH = 3;
    localparam int SORT_DEPTH = 4;

endpackage

// File: rtl/mag_compare.sv
// Unsigned magnitude comparator built on a single borrow-extended subtraction.
module mag_compare #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             is_lt,
    output logic             is_gt,
    output logic             is_eq
);

    logic [WIDTH:0] diff;

    // The extra top bit catches the borrow, so 0 vs max still orders correctly.
    assign diff  = {1'b0, a} - {1'b0, b};
    assign is_lt = diff[WIDTH];
    assign is_eq = (diff[WIDTH-1:0] == '0);
    assign is_gt = ~is_lt & ~is_eq;

endmodule

// File: rtl/sort_ctrl.sv
// Loads DEPTH words, bubble-sorts them in place through one shared comparator, streams them out.
// Define SORT_DESC_EN to swap on is_lt instead of is_gt, giving descending output.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int DEPTH = SORT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [IW-1:0] PEND = IW'(DEPTH - 2);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    wr;
    logic [IW-1:0]    rd;
    logic [IW-1:0]    j;
    logic [IW-1:0]    pass;
    logic             swapped;

    logic [IW-1:0]    j_nxt;
    logic             is_lt;
    logic             is_gt;
    logic             is_eq;
    logic             do_swap;
    logic             pass_swapped;
    logic [WIDTH-1:0] head_next;
    logic             cmp_unused;

    assign j_nxt = j + ONE;

    mag_compare #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a     (mem[j]),
        .b     (mem[j_nxt]),
        .is_lt (is_lt),
        .is_gt (is_gt),
        .is_eq (is_eq)
    );

`ifdef SORT_DESC_EN
    assign do_swap = (state == SORT) && is_lt;
`else
    assign do_swap = (state == SORT) && is_gt;
`endif

    assign cmp_unused   = &{is_lt, is_gt, is_eq};
    assign pass_swapped = swapped | do_swap;
    // Word 0 as it will look after this cycle's swap, so out_data is ready on entry to OUT.
    assign head_next    = (do_swap && (j == '0)) ? mem[1] : mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            wr        <= '0;
            rd        <= '0;
            j         <= '0;
            pass      <= '0;
            swapped   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem[wr] <= in_data;
                        if (wr == LAST) begin
                            wr       <= '0;
                            j        <= '0;
                            pass     <= '0;
                            swapped  <= 1'b0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SORT;
                        end else begin
                            wr <= wr + ONE;
                        end
                    end
                end

                SORT: begin
                    if (do_swap) begin
                        mem[j]     <= mem[j_nxt];
                        mem[j_nxt] <= mem[j];
                    end
                    if (j == PEND) begin
                        // A clean pass, or the last pass, means the buffer is ordered.
                        if (!pass_swapped || (pass == PEND)) begin
                            j         <= '0;
                            rd        <= '0;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= head_next;
                            state     <= OUT;
                        end else begin
                            pass    <= pass + ONE;
                            j       <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        j       <= j_nxt;
                        swapped <= pass_swapped;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        if (rd == LAST) begin
                            rd        <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            rd       <= rd + ONE;
                            out_data <= mem[rd + ONE];
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl: expected sorted words are queued at load and popped on each output transfer.
module tb_sort_ctrl;
    import sort_pkg::*;

    localparam int W = SORT_WIDTH;
    localparam int D = SORT_DEPTH;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b1;
    logic         busy;

    int           n_checks  = 0;
    int           n_errors  = 0;
    int           busy_cnt  = 0;
    logic [W-1:0] exp_q [$];

    sort_ctrl #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [D*W-1:0] pk(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Output monitor and busy-cycle counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_extra", exp_q.size(), 1);
                else check("out_word", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic load_words(input logic [D*W-1:0] words, input int gaps);
        for (int i = 0; i < D; i++) begin
            if (gaps > 0 && i > 0) begin
                in_valid = 1'b0;
                in_data  = '1;
                repeat (gaps) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = words[i*W +: W];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic run_batch(input string name, input logic [D*W-1:0] words,
                             input logic [D*W-1:0] exp_words, input int exp_cycles,
                             input int gaps, input int stall);
        int t;
        logic [W-1:0] held;
        busy_cnt = 0;
        for (int i = 0; i < D; i++) exp_q.push_back(exp_words[i*W +: W]);
        out_ready = (stall == 0);
        load_words(words, gaps);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!out_valid && t < 40);
        check({name, "_ovalid"}, out_valid, 1);
        check({name, "_cycles"}, busy_cnt, exp_cycles);
        if (stall > 0) begin
            held = out_data;
            check({name, "_head"}, held, exp_q.size() > 0 ? exp_q[0] : '0);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                #1;
                check({name, "_stall_valid"}, out_valid, 1);
                check({name, "_stall_data"}, out_data, held);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_out_valid_end"}, out_valid, 0);
        exp_q.delete();
    endtask

`ifdef SORT_DESC_EN
    localparam int C_A = 6, C_B = 9, C_C = 6, C_D = 3, C_E = 9, C_F = 9, C_G = 9;
    logic [D*W-1:0] e_a, e_b, e_c, e_d, e_e, e_f, e_g;
    initial begin
        e_a = pk(3,2,1,0); e_b = pk(3,2,1,0); e_c = pk(7,6,1,0); e_d = pk(5,5,5,5);
        e_e = pk(3,2,1,0); e_f = pk(7,6,4,2); e_g = pk(3,2,2,1);
    end
`else
    localparam int C_A = 9, C_B = 3, C_C = 9, C_D = 3, C_E = 9, C_F = 9, C_G = 9;
    logic [D*W-1:0] e_a, e_b, e_c, e_d, e_e, e_f, e_g;
    initial begin
        e_a = pk(0,1,2,3); e_b = pk(0,1,2,3); e_c = pk(0,1,6,7); e_d = pk(5,5,5,5);
        e_e = pk(0,1,2,3); e_f = pk(2,4,6,7); e_g = pk(1,2,2,3);
    end
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_batch("rev",    pk(3,1,2,0), e_a, C_A, 0, 0);
        run_batch("sorted", pk(0,1,2,3), e_b, C_B, 0, 0);
        run_batch("wrap",   pk(7,0,6,1), e_c, C_C, 0, 0);
        run_batch("equal",  pk(5,5,5,5), e_d, C_D, 0, 0);
        run_batch("gaps",   pk(1,3,0,2), e_e, C_E, 2, 0);
        run_batch("stall",  pk(6,4,7,2), e_f, C_F, 0, 4);

        // Abort a batch mid-sort with an asynchronous reset.
        out_ready = 1'b1;
        load_words(pk(3,1,2,0), 0);
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_batch("after_rst", pk(2,2,1,3), e_g, C_G, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
